// File: rtl/reset_release_seq.sv
// reset_release_seq: synchronized iPreset release, stretch, then staggered domain release.
// Optional RSTSEQ_SWREQ_EN lets iSwReq re-run the sequence from RUN.
module reset_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int GAP         = 2,
  parameter int NUM_DOM     = 4
) (
  input  logic               iClock,
  input  logic               iPreset,
  input  logic               iSwReq,
  input  logic               iHoldOff,
  output logic [NUM_DOM-1:0] oReset,
  output logic               oDone,
  output logic               oBusy
);

  localparam int CW = $clog2(STRETCH + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_RST,
    S_SYNC,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [NUM_DOM-1:0]     rst_d;
  logic [NUM_DOM-1:0]     rst_shift;
  logic                   done_d;
  logic                   busy_d;
  logic                   sync_hit;
  logic                   sw_req;

`ifdef RSTSEQ_SWREQ_EN
  assign sw_req = iSwReq;
`else
  logic unused_swreq;
  assign unused_swreq = iSwReq;
  assign sw_req       = 1'b0;
`endif

  // Last stage becomes 1 on this edge
  assign sync_hit = sync_q[SYNC_STAGES-2];

  // Thermometer step: release the next domain
  always_comb begin
    rst_shift    = '0;
    rst_shift[0] = 1'b1;
    for (int i = 1; i < NUM_DOM; i++)
      rst_shift[i] = oReset[i-1];
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    rst_d   = oReset;
    done_d  = oDone;
    busy_d  = oBusy;
    unique case (state)
      S_RST: begin
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if (sync_hit) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_STRETCH: begin
        if (cnt_q == CW'(STRETCH - 1)) begin
          rst_d = rst_shift;
          gap_d = '0;
          if (rst_shift[NUM_DOM-1]) begin
            state_d = S_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!iHoldOff) begin
          if (gap_q == GW'(GAP - 1)) begin
            gap_d = '0;
            rst_d = rst_shift;
            if (rst_shift[NUM_DOM-1]) begin
              state_d = S_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (sw_req) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
          gap_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_RST;
        rst_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iPreset) begin
    if (!iPreset) begin
      state  <= S_RST;
      sync_q <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
      oReset <= '0;
      oDone  <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      state  <= state_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
      oReset <= rst_d;
      oDone  <= done_d;
      oBusy  <= busy_d;
    end
  end

endmodule

// File: doc/reset_release_seq.md
RESET_RELEASE_SEQ -- requirements
Module: reset_release_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on the iPreset release path (legal 2..4).
REQ-002 SHALL have parameter STRETCH, default 16, cycles reset is held after synchronized release (legal 1..255).
REQ-003 SHALL have parameter GAP, default 2, cycles between successive domain releases (legal 1..255).
REQ-004 SHALL have parameter NUM_DOM, default 4, number of sequenced reset outputs (legal 1..16).
REQ-005 SHALL have port iClock  input  1  rising-edge clock.
REQ-006 SHALL have port iPreset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port iSwReq  input  1  software reset request, sampled on iClock.
REQ-008 SHALL have port iHoldOff  input  1  pauses domain release while high.
REQ-009 SHALL have port oReset  output  NUM_DOM  per-domain reset, active-low, index 0 released first.
REQ-010 SHALL have port oDone  output  1  high when all domains released.
REQ-011 SHALL have port oBusy  output  1  high while sequence in progress (STRETCH or RELEASE).

Function
REQ-012 SHALL implement states RST, SYNC, STRETCH, RELEASE, RUN; all outputs registered.
REQ-013 SHALL shift constant 1 through SYNC_STAGES flops after iPreset deassertion; leave SYNC when last stage is 1 (edge SYNC_STAGES after release, edge 1 = first rising edge with iPreset high).
REQ-014 SHALL count STRETCH cycles in STRETCH, then enter RELEASE; counter width $clog2(STRETCH+1).
REQ-015 SHALL drive oReset[0] high at edge SYNC_STAGES+STRETCH and oReset[i] high exactly GAP edges after oReset[i-1].
REQ-016 SHALL freeze the gap counter and withhold further releases on any edge where iHoldOff is sampled 1; already-released domains stay released.
REQ-017 SHALL enter RUN and assert oDone on the same edge oReset[NUM_DOM-1] goes high; oBusy low in RST, SYNC, RUN.
REQ-018 SHALL never deassert a higher-index domain before a lower-index one; once released, a domain stays high until reset or software request.
REQ-019 SHALL ignore iHoldOff outside RELEASE and iSwReq outside RUN (no latching).

Reset
REQ-020 SHALL, while iPreset low, asynchronously force oReset all 0, oDone 0, oBusy 0, synchronizer chain 0, counters 0, state RST.
REQ-021 SHALL, on iPreset assertion mid-sequence or in RUN, abort immediately and restart the full sequence from SYNC on release.
REQ-022 SHALL never deassert any oReset asynchronously; deassertion only on iClock rising edges.

Configuration
REQ-023 SHALL compile software reset support only when macro RSTSEQ_SWREQ_EN is defined.
REQ-024 SHALL, with RSTSEQ_SWREQ_EN, on iSwReq sampled 1 in RUN, drive all oReset 0 and oDone 0 at that edge and enter STRETCH (SYNC skipped), then release per REQ-014..017.
REQ-025 SHALL, without RSTSEQ_SWREQ_EN, keep port iSwReq but ignore it entirely; RUN exits only via iPreset.

Verification (SYNC_STAGES=2, STRETCH=4, GAP=2, NUM_DOM=4)
REQ-026 SHALL verify power-up: iPreset low 3 cycles then high -> oReset[0..3] high at edges 6, 8, 10, 12; oDone high at edge 12; oBusy high edges 2..11.
REQ-027 SHALL verify hold-off: iHoldOff=1 sampled at edges 7..9 -> oReset[1] high at edge 11, oReset[3] and oDone at edge 15.
REQ-028 SHALL verify mid-sequence reset: iPreset low between edges 9 and 10 -> oReset=4'b0000 immediately without clock, sequence restarts, oReset[0] at edge 6 after new release.
REQ-029 SHALL verify software request (macro defined): iSwReq=1 at edge k in RUN -> oReset=0, oDone=0 at k; oReset[0] at k+4, oReset[3] and oDone at k+10.
REQ-030 SHALL verify macro undefined: iSwReq pulsed in RUN -> oReset stays 4'b1111, oDone stays 1.
REQ-031 SHALL verify iPreset glitch of under one clock period -> all oReset low during glitch; no oReset high earlier than edge 6 after release.
